// File: rtl/minitb_ahb_slave_mem_if.sv
// AHB-Lite bus bundle between the miniTB master BFM and the slave memory model.
// hready_in is the bus-level ready; a single-slave bench ties it to hready.
interface minitb_ahb_slave_mem_if #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
);
  logic                 hsel;
  logic [1:0]           htrans;
  logic [addrWidth-1:0] haddr;
  logic                 hwrite;
  logic [dataWidth-1:0] hwdata;
  logic                 hready_in;
  logic                 hready;
  logic                 hresp;
  logic [dataWidth-1:0] hrdata;

  modport master (
    output hsel, htrans, haddr, hwrite, hwdata, hready_in,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, haddr, hwrite, hwdata, hready_in,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/minitb_ahb_slave_mem.sv
// AHB-Lite slave memory: word-indexed storage, waitStates hready-low cycles per OKAY
// data phase, two-cycle ERROR response for addresses at or beyond depth.
module minitb_ahb_slave_mem #(
  parameter int addrWidth  = 8,
  parameter int dataWidth  = 32,
  parameter int depth      = 128,
  parameter int waitStates = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  minitb_ahb_slave_mem_if.slave bus
);

  localparam int IdxW = (depth > 1) ? $clog2(depth) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e               state_q;
  logic                 hready_q;
  logic                 hresp_q;
  logic [3:0]           cnt_q;
  logic [addrWidth-1:0] addr_q;
  logic                 write_q;
  logic                 err_q;
  logic [dataWidth-1:0] mem_q [depth];

  logic                 accept;
  logic                 err_d;
  logic [IdxW-1:0]      idx;
  logic                 unused_bits;

  assign accept      = bus.hsel && bus.htrans[1] && bus.hready_in;
  assign err_d       = 32'(bus.haddr) >= 32'(depth);
  assign idx         = addr_q[IdxW-1:0];
  assign unused_bits = ^{bus.htrans[0], addr_q};

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= S_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= S_DATA;
            hready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all end with hready high, so each may take a new address phase.
          if (accept) begin
            addr_q  <= bus.haddr;
            write_q <= bus.hwrite;
            err_q   <= err_d;
            if (err_d) begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (waitStates > 0) begin
              state_q  <= S_WAIT;
              cnt_q    <= 4'(waitStates - 1);
              hready_q <= 1'b0;
              hresp_q  <= 1'b0;
            end else begin
              state_q  <= S_DATA;
              hready_q <= 1'b1;
              hresp_q  <= 1'b0;
            end
          end else begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset; a reset edge drops any write still in flight.
  always_ff @(posedge hclk) begin
    if (!hreset && state_q == S_DATA && write_q && !err_q) begin
      mem_q[idx] <= bus.hwdata;
    end
  end

  assign bus.hready = hready_q;
  assign bus.hresp  = hresp_q;
  assign bus.hrdata = (state_q == S_DATA && !write_q) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Bench for minitb_ahb_slave_mem: three instances (waitStates 0, 1, 2) driven by a
// pipelining AHB driver and checked every cycle against a transaction-level model.
module tb_minitb_ahb_slave_mem;

  logic        clk;
  logic        rst_a     [3];
  logic        hsel_a    [3];
  logic [1:0]  htrans_a  [3];
  logic [7:0]  haddr_a   [3];
  logic        hwrite_a  [3];
  logic [31:0] hwdata_a  [3];
  logic        hready_a  [3];
  logic        hresp_a   [3];
  logic [31:0] hrdata_a  [3];

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    minitb_ahb_slave_mem_if #(.addrWidth(8), .dataWidth(32)) bus ();
    assign bus.hsel      = hsel_a[g];
    assign bus.htrans    = htrans_a[g];
    assign bus.haddr     = haddr_a[g];
    assign bus.hwrite    = hwrite_a[g];
    assign bus.hwdata    = hwdata_a[g];
    assign bus.hready_in = bus.hready;
    assign hready_a[g]   = bus.hready;
    assign hresp_a[g]    = bus.hresp;
    assign hrdata_a[g]   = bus.hrdata;

    minitb_ahb_slave_mem #(
      .addrWidth(8), .dataWidth(32), .depth(128), .waitStates(g)
    ) u_dut (
      .hclk  (clk),
      .hreset(rst_a[g]),
      .bus   (bus)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: each accepted transfer expands into its list of per-cycle bus responses.
  typedef struct packed {
    logic       rdy;
    logic       resp;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
  } exp_t;

  localparam exp_t IDLE_E = '{rdy: 1'b1, resp: 1'b0, rd: 1'b0, wr: 1'b0, addr: 8'h0};

  exp_t        mq      [3][$];
  logic [31:0] mdl_mem [3][256];
  bit          mdl_vld [3][256];

  initial begin
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 256; a++) mdl_vld[k][a] = 1'b0;
  end

  always @(posedge clk) begin : mdl_upd
    exp_t cur;
    for (int k = 0; k < 3; k++) begin
      if (rst_a[k] === 1'b1) begin
        mq[k].delete();
      end else begin
        cur = IDLE_E;
        if (mq[k].size() > 0) cur = mq[k].pop_front();
        if (cur.wr) begin
          mdl_mem[k][cur.addr] = hwdata_a[k];
          mdl_vld[k][cur.addr] = 1'b1;
        end
        if (cur.rdy && hsel_a[k] === 1'b1 && htrans_a[k][1] === 1'b1) begin
          if (haddr_a[k] >= 8'd128) begin
            mq[k].push_back('{rdy: 1'b0, resp: 1'b1, rd: 1'b0, wr: 1'b0, addr: haddr_a[k]});
            mq[k].push_back('{rdy: 1'b1, resp: 1'b1, rd: 1'b0, wr: 1'b0, addr: haddr_a[k]});
          end else begin
            repeat (k) mq[k].push_back('{rdy: 1'b0, resp: 1'b0, rd: 1'b0, wr: 1'b0, addr: haddr_a[k]});
            mq[k].push_back('{rdy: 1'b1, resp: 1'b0, rd: !hwrite_a[k], wr: hwrite_a[k], addr: haddr_a[k]});
          end
        end
      end
    end
  end

  always @(negedge clk) begin : mdl_cmp
    exp_t cur;
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        cur = IDLE_E;
        if (mq[k].size() > 0) cur = mq[k][0];
        check($sformatf("model_hready[%0d]", k), {31'd0, hready_a[k]}, {31'd0, cur.rdy});
        check($sformatf("model_hresp[%0d]", k), {31'd0, hresp_a[k]}, {31'd0, cur.resp});
        if (!cur.rd)
          check($sformatf("model_hrdata_zero[%0d]", k), hrdata_a[k], 32'h0);
        else if (mdl_vld[k][cur.addr])
          check($sformatf("model_hrdata[%0d]", k), hrdata_a[k], mdl_mem[k][cur.addr]);
      end
    end
  end

  // Transfer list and per-cycle logs for the pipelining driver.
  logic [7:0]  tr_addr [16];
  logic        tr_wr   [16];
  logic [31:0] tr_dat  [16];
  int          tr_n = 0;
  logic        rdy_log  [64];
  logic        resp_log [64];
  logic [31:0] rd_log   [64];
  int          log_n = 0;

  task automatic add(input logic [7:0] a, input logic w, input logic [31:0] d);
    tr_addr[tr_n] = a;
    tr_wr[tr_n]   = w;
    tr_dat[tr_n]  = d;
    tr_n++;
  endtask

  task automatic bus_idle(input int k);
    hsel_a[k]   = 1'b0;
    htrans_a[k] = 2'b00;
    haddr_a[k]  = 8'h0;
    hwrite_a[k] = 1'b0;
  endtask

  task automatic run(input int k);
    int   i   = 0;
    int   dph = -1;
    int   cyc = 0;
    logic r;
    log_n = 0;
    while ((i < tr_n || dph >= 0) && cyc < 60) begin
      if (i < tr_n) begin
        hsel_a[k]   = 1'b1;
        htrans_a[k] = 2'b10;
        haddr_a[k]  = tr_addr[i];
        hwrite_a[k] = tr_wr[i];
      end else begin
        bus_idle(k);
      end
      hwdata_a[k] = (dph >= 0 && tr_wr[dph]) ? tr_dat[dph] : 32'h0;
      @(negedge clk);
      r               = hready_a[k];
      rdy_log[log_n]  = r;
      resp_log[log_n] = hresp_a[k];
      rd_log[log_n]   = hrdata_a[k];
      log_n++;
      @(posedge clk);
      #1;
      cyc++;
      if (r === 1'b1) begin
        if (i < tr_n) begin
          dph = i;
          i++;
        end else begin
          dph = -1;
        end
      end
    end
    if (i < tr_n || dph >= 0) begin
      tests++;
      fails++;
      $display("FAIL run_timeout[%0d]: got %0d cycles without completion, expected completion", k, cyc);
    end
    bus_idle(k);
    tr_n = 0;
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: got time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    for (int k = 0; k < 3; k++) begin
      rst_a[k]    = 1'b1;
      hwdata_a[k] = 32'h0;
      bus_idle(k);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_a[k] = 1'b0;
    chk_on = 1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_hready[%0d]", k), {31'd0, hready_a[k]}, 32'd1);
      check($sformatf("reset_hresp[%0d]", k), {31'd0, hresp_a[k]}, 32'd0);
      check($sformatf("reset_hrdata[%0d]", k), hrdata_a[k], 32'd0);
    end
    @(posedge clk);
    #1;

    // Zero-wait write then back-to-back read of the same word.
    add(8'h05, 1'b1, 32'hDEADBEEF);
    add(8'h05, 1'b0, 32'h0);
    run(0);
    check("raw_cycles", log_n, 3);
    check("raw_hready_wr", {31'd0, rdy_log[1]}, 32'd1);
    check("raw_hready_rd", {31'd0, rdy_log[2]}, 32'd1);
    check("raw_hrdata", rd_log[2], 32'hDEADBEEF);

    // Two wait states on both write and read.
    add(8'h10, 1'b1, 32'h12345678);
    add(8'h10, 1'b0, 32'h0);
    run(2);
    check("ws2_cycles", log_n, 7);
    cnt = 0;
    for (int c = 4; c < 7; c++) if (rdy_log[c] === 1'b0) cnt++;
    check("ws2_read_low_cycles", cnt, 2);
    check("ws2_hready_final", {31'd0, rdy_log[6]}, 32'd1);
    check("ws2_hrdata", rd_log[6], 32'h12345678);

    // Out-of-range write must not alias into word 0x48.
    add(8'h48, 1'b1, 32'hCAFEF00D);
    add(8'hC8, 1'b1, 32'h00000001);
    add(8'h48, 1'b0, 32'h0);
    run(0);
    check("err1_hready", {31'd0, rdy_log[2]}, 32'd0);
    check("err1_hresp", {31'd0, resp_log[2]}, 32'd1);
    check("err2_hready", {31'd0, rdy_log[3]}, 32'd1);
    check("err2_hresp", {31'd0, resp_log[3]}, 32'd1);
    check("err_no_alias", rd_log[4], 32'hCAFEF00D);

    // Highest legal word, then an unselected write that must be ignored.
    add(8'h7F, 1'b1, 32'hA5A5A5A5);
    add(8'h7F, 1'b0, 32'h0);
    run(0);
    check("top_hresp", {31'd0, resp_log[2]}, 32'd0);
    check("top_hrdata", rd_log[2], 32'hA5A5A5A5);
    hsel_a[0]   = 1'b0;
    htrans_a[0] = 2'b10;
    haddr_a[0]  = 8'h7F;
    hwrite_a[0] = 1'b1;
    hwdata_a[0] = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("nosel_hready", {31'd0, hready_a[0]}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus_idle(0);
    add(8'h7F, 1'b0, 32'h0);
    run(0);
    check("nosel_no_write", rd_log[1], 32'hA5A5A5A5);

    // Reset during the wait state of a write drops that write.
    add(8'h03, 1'b1, 32'h00000011);
    run(1);
    hsel_a[1]   = 1'b1;
    htrans_a[1] = 2'b10;
    haddr_a[1]  = 8'h03;
    hwrite_a[1] = 1'b1;
    @(posedge clk);
    #1;
    bus_idle(1);
    hwdata_a[1] = 32'h77;
    rst_a[1]    = 1'b1;
    @(negedge clk);
    check("rst_in_wait_hready", {31'd0, hready_a[1]}, 32'd0);
    @(posedge clk);
    #1;
    rst_a[1] = 1'b0;
    @(negedge clk);
    check("rst_after_hready", {31'd0, hready_a[1]}, 32'd1);
    check("rst_after_hresp", {31'd0, hresp_a[1]}, 32'd0);
    check("rst_after_hrdata", hrdata_a[1], 32'd0);
    @(posedge clk);
    #1;
    add(8'h03, 1'b0, 32'h0);
    run(1);
    check("rst_dropped_write", rd_log[2], 32'h00000011);

    // Four pipelined writes followed by four pipelined reads.
    for (int a = 0; a < 4; a++) add(8'(a), 1'b1, 32'(a + 1));
    for (int a = 0; a < 4; a++) add(8'(a), 1'b0, 32'h0);
    run(0);
    cnt = 0;
    for (int c = 1; c < 9; c++) if (rdy_log[c] === 1'b1) cnt++;
    check("b2b_hready_high", cnt, 8);
    check("b2b_rd0", rd_log[5], 32'd1);
    check("b2b_rd1", rd_log[6], 32'd2);
    check("b2b_rd2", rd_log[7], 32'd3);
    check("b2b_rd3", rd_log[8], 32'd4);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/minitb_ahb_slave_mem.md
Name: minitb_ahb_slave_mem

Overview:
- AHB-Lite slave memory model that sits directly downstream of the miniTB AHB master BFM.
- Consumes the master's address/control/write-data phases and returns hrdata, hready and hresp.
- Word-indexed register-array storage with a parameterised number of wait states.
- Out-of-range addresses get the two-cycle AHB ERROR response, so master stall, read-data and pipelining behaviour can be exercised against real RTL.

Parameters:
- addrWidth, 8, width of haddr; haddr is used directly as the word index.
- dataWidth, 32, width of hwdata/hrdata.
- depth, 128, number of storage words; index >= depth is out of range.
- waitStates, 0, hready-low cycles inserted in every OKAY data phase (0..15).

Ports:
- hclk  input  1  bus clock; all logic on posedge.
- hreset  input  1  synchronous, active-high reset.
- hsel  input  1  slave select.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- haddr  input  addrWidth  transfer address (word index).
- hwrite  input  1  1=write, 0=read.
- hwdata  input  dataWidth  write data, valid in data phase.
- hready_in  input  1  bus-level hready; tied to hready in a single-slave bench.
- hready  output  1  slave ready / data-phase complete.
- hresp  output  1  0=OKAY, 1=ERROR.
- hrdata  output  dataWidth  read data.

Behaviour:
- Reset values (edge with hreset=1): state=IDLE, hready=1, hresp=0, hrdata=0, wait counter=0, captured control cleared.
- Memory contents are not reset and keep their values across reset.
- Address-phase accept: at posedge when hsel && htrans[1] && hready_in. Capture addr_q, write_q, err_q=(haddr>=depth).
- IDLE and BUSY are never accepted. When hready_in=0 the slave ignores the address bus.
- States:
  - IDLE: hready=1, hresp=0. On accept: if err_q go to ERR1; else if waitStates>0 go to WAIT with cnt=waitStates-1; else go to DATA.
  - WAIT: hready=0. Decrement cnt; at cnt==0 go to DATA.
  - DATA: hready=1, hresp=0. Final data-phase cycle. On the ending posedge: if write_q, mem[addr_q]<=hwdata. Next state follows the accept rule (back-to-back pipelining); if no accept, go to IDLE.
  - ERR1: hready=0, hresp=1. Always go to ERR2.
  - ERR2: hready=1, hresp=1. No memory access. Next state follows the accept rule.
- Read data: in DATA with write_q=0, hrdata=mem[addr_q] combinationally. Otherwise hrdata=0.
- Zero-wait pipelining: a new address phase is accepted in the same cycle as the previous transfer's DATA cycle. Throughput is one transfer per cycle at waitStates=0.
- Read-after-write, same address, back-to-back: the write commits on the edge that starts the read's data phase, so the read returns the new data. No forwarding path is needed.
- During WAIT/ERR1, hready=0 holds the master's next address. It is not captured until hready is high.
- Address or control changes while hready=0 are ignored.
- hsel=0 with htrans=NONSEQ: no accept, slave stays/returns IDLE, hready=1.
- SEQ is treated as NONSEQ (no burst address check).
- Reset mid-transfer: pending write is dropped (no commit), state returns to IDLE, hready=1 on the cycle after the reset edge.
- haddr == depth-1: OKAY. haddr == depth: ERROR.

Test Plan:
- waitStates=0: write 0x5 <- 0xDEADBEEF, then read 0x5 back-to-back → hready stays 1; hrdata=0xDEADBEEF in the read data cycle exactly 2 cycles after the write address phase.
- waitStates=2: read 0x10 after writing 0x12345678 → hready low for exactly 2 cycles; 3-cycle data phase; hrdata=0x12345678 with hready=1.
- Write 0xC8 (>=128) data 0x1 → ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1); subsequent read of 0x48 (0xC8 aliasing 0x48) shows no corruption.
- Write 0x7F <- 0xA5A5A5A5 and read 0x7F → OKAY, data returned. htrans=NONSEQ with hsel=0 → no access, hready=1.
- waitStates=1: assert hreset during WAIT of a write to 0x3 <- 0x77 → mem[0x3] keeps its prior value; hready=1, hresp=0, hrdata=0 on the next cycle.
- Four back-to-back NONSEQ writes (0x0..0x3 <- 1..4) then four reads at waitStates=0 → 8 consecutive hready=1 cycles; reads return 1, 2, 3, 4.
